// File: rtl/jellyvl_cdc_array_stabilizer_pkg.sv
// jellyvl_cdc_array_stabilizer_pkg: shared sizing helper for the CDC array stabilizer
package jellyvl_cdc_array_stabilizer_pkg;

    // Width of a counter able to hold 0..n inclusive
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/jellyvl_cdc_array_stabilizer_if.sv
// jellyvl_cdc_array_stabilizer_if: synchronized bus in, coherent bus and status pulses out
interface jellyvl_cdc_array_stabilizer_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] out_data;
    logic             out_changed;
    logic             out_stable;
    logic             out_glitch;

    modport master (
        output in_data,
        input  out_data,
        input  out_changed,
        input  out_stable,
        input  out_glitch
    );

    modport slave (
        input  in_data,
        output out_data,
        output out_changed,
        output out_stable,
        output out_glitch
    );
endinterface

// File: rtl/jellyvl_cdc_array_stabilizer.sv
// jellyvl_cdc_array_stabilizer: accepts a bus value only after STABLE_CYCLES identical samples
module jellyvl_cdc_array_stabilizer
    import jellyvl_cdc_array_stabilizer_pkg::*;
#(
    parameter int               WIDTH         = 2,
    parameter int               STABLE_CYCLES = 3,
    parameter int               CNT_WIDTH     = cnt_width(STABLE_CYCLES),
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
    input logic clk,
    input logic reset,
    jellyvl_cdc_array_stabilizer_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] RUN_MAX = CNT_WIDTH'(STABLE_CYCLES);

    logic [WIDTH-1:0]     last;
    logic [CNT_WIDTH-1:0] run;
    logic [CNT_WIDTH-1:0] run_next;
    logic                 diff;
    logic                 reaching;

    // Run-length bookkeeping; a fresh sample counts as reaching when one sample is enough
    always_comb begin
        diff     = bus.in_data != last;
        run_next = diff ? CNT_WIDTH'(1) : (run == RUN_MAX ? RUN_MAX : run + 1'b1);
        reaching = run_next == RUN_MAX && (run != RUN_MAX || diff);
    end

    // Registered state and outputs; nothing combinational reaches the outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            last            <= INIT_VALUE;
            run             <= RUN_MAX;
            bus.out_data    <= INIT_VALUE;
            bus.out_changed <= 1'b0;
            bus.out_stable  <= 1'b1;
            bus.out_glitch  <= 1'b0;
        end else begin
            last            <= bus.in_data;
            run             <= run_next;
            bus.out_data    <= reaching ? bus.in_data : bus.out_data;
            bus.out_changed <= reaching && bus.in_data != bus.out_data;
            bus.out_stable  <= run_next == RUN_MAX;
            bus.out_glitch  <= diff && run < RUN_MAX;
        end
    end

endmodule

// File: tb/tb_jellyvl_cdc_array_stabilizer.sv
// tb_jellyvl_cdc_array_stabilizer: directed checks on a 3-cycle and a 1-cycle stabilizer
module tb_jellyvl_cdc_array_stabilizer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    jellyvl_cdc_array_stabilizer_if #(.WIDTH(4)) a_if ();
    jellyvl_cdc_array_stabilizer_if #(.WIDTH(4)) b_if ();

    jellyvl_cdc_array_stabilizer #(.WIDTH(4), .STABLE_CYCLES(3), .INIT_VALUE(4'h0)) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (a_if.slave)
    );

    jellyvl_cdc_array_stabilizer #(.WIDTH(4), .STABLE_CYCLES(1), .INIT_VALUE(4'h0)) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (b_if.slave)
    );

    always #5 clk = ~clk;

    logic [6:0] got_a;
    logic [6:0] got_b;
    assign got_a = {a_if.out_data, a_if.out_changed, a_if.out_stable, a_if.out_glitch};
    assign got_b = {b_if.out_data, b_if.out_changed, b_if.out_stable, b_if.out_glitch};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_if.in_data = 4'h0;
        b_if.in_data = 4'h0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (got_a !== {4'h0, 3'b010}) begin
                failures++;
                $display("FAIL reset_idle cycle %0d got {data,chg,stb,glt}=%h expected %h", i, got_a, {4'h0, 3'b010});
            end
        end
    endtask

    task automatic test_step();
        logic [6:0] exp [5] = '{{4'h0, 3'b000}, {4'h0, 3'b000}, {4'h5, 3'b110}, {4'h5, 3'b010}, {4'h5, 3'b010}};
        do_reset();
        a_if.in_data = 4'h5;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (got_a !== exp[i]) begin
                failures++;
                $display("FAIL step edge %0d got %h expected %h", i, got_a, exp[i]);
            end
        end
    endtask

    task automatic test_glitch_replace();
        logic [6:0] exp [5] = '{{4'h0, 3'b000}, {4'h0, 3'b001}, {4'h0, 3'b000}, {4'hA, 3'b110}, {4'hA, 3'b010}};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            a_if.in_data = (i == 0) ? 4'h5 : 4'hA;
            tick();
            checks++;
            if (got_a !== exp[i]) begin
                failures++;
                $display("FAIL glitch_replace edge %0d got %h expected %h", i, got_a, exp[i]);
            end
        end
    endtask

    task automatic test_glitch_return();
        logic [6:0] exp [6] = '{{4'h0, 3'b000}, {4'h0, 3'b000}, {4'h0, 3'b001}, {4'h0, 3'b000}, {4'h0, 3'b010}, {4'h0, 3'b010}};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            a_if.in_data = (i < 2) ? 4'h5 : 4'h0;
            tick();
            checks++;
            if (got_a !== exp[i]) begin
                failures++;
                $display("FAIL glitch_return edge %0d got %h expected %h", i, got_a, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [6:0] exp [5] = '{{4'h0, 3'b000}, {4'h0, 3'b010}, {4'h0, 3'b000}, {4'h0, 3'b000}, {4'h7, 3'b110}};
        do_reset();
        a_if.in_data = 4'h7;
        for (int i = 0; i < 5; i++) begin
            reset = (i == 1);
            tick();
            checks++;
            if (got_a !== exp[i]) begin
                failures++;
                $display("FAIL reset_mid_run edge %0d got %h expected %h", i, got_a, exp[i]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single_cycle();
        logic [3:0] v;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            v = (i % 2 == 0) ? 4'h1 : 4'h2;
            b_if.in_data = v;
            tick();
            checks++;
            if (got_b !== {v, 3'b110}) begin
                failures++;
                $display("FAIL single_toggle edge %0d got %h expected %h", i, got_b, {v, 3'b110});
            end
        end
        tick();
        checks++;
        if (got_b !== {4'h2, 3'b010}) begin
            failures++;
            $display("FAIL single_hold got %h expected %h", got_b, {4'h2, 3'b010});
        end
    endtask

    initial begin
        a_if.in_data = 4'h0;
        b_if.in_data = 4'h0;
        test_reset();
        test_step();
        test_glitch_replace();
        test_glitch_return();
        test_reset_mid_run();
        test_single_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
